// File: rtl/windowed_register_file_if.sv
// Decode-side bundle for the windowed register file: register selects, write port,
// window op and WIM in; registered operands, CWP and trap pulses out.
interface windowed_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NWINDOWS   = 4
);
    localparam int CWP_W = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1;

    logic [4:0]            Register_A_Select;
    logic [4:0]            Register_B_Select;
    logic [DATA_WIDTH-1:0] Register_A;
    logic [DATA_WIDTH-1:0] Register_B;
    logic                  Write_Enable;
    logic [4:0]            Write_Select;
    logic [DATA_WIDTH-1:0] Write_Data;
    logic [1:0]            CWP_Op;
    logic [NWINDOWS-1:0]   WIM;
    logic [CWP_W-1:0]      CWP;
    logic                  Window_Overflow;
    logic                  Window_Underflow;

    modport master (
        output Register_A_Select, Register_B_Select, Write_Enable, Write_Select,
               Write_Data, CWP_Op, WIM,
        input  Register_A, Register_B, CWP, Window_Overflow, Window_Underflow
    );

    modport slave (
        input  Register_A_Select, Register_B_Select, Write_Enable, Write_Select,
               Write_Data, CWP_Op, WIM,
        output Register_A, Register_B, CWP, Window_Overflow, Window_Underflow
    );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: 8 globals plus NWINDOWS overlapping windows,
// two registered read ports with write bypass, and a SAVE/RESTORE-driven CWP with WIM traps.
module windowed_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NWINDOWS   = 4,
    parameter int CWP_RESET  = 0
) (
    input logic                   Clk,
    input logic                   Reset_N,
    windowed_register_file_if.slave rf
);
    localparam int CWP_W  = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1;
    localparam int NPHYS  = 8 + 16 * NWINDOWS;
    localparam int PHYS_W = $clog2(NPHYS);

    typedef logic [PHYS_W-1:0] phys_t;
    typedef logic [CWP_W-1:0]  cwp_t;

    logic [DATA_WIDTH-1:0] regs [NPHYS];
    logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q, rd_a_d, rd_b_d;
    cwp_t                  cwp_q, cwp_d, cwp_inc, cwp_dec;
    logic                  ovf_q, unf_q, ovf_d, unf_d;
    phys_t                 idx_a, idx_b, idx_w;
    logic                  wr_en;

    // Ins of window w are the outs of window w+1, so the ins base uses the incremented CWP.
    function automatic phys_t map_reg(input logic [4:0] sel, input cwp_t cwp, input cwp_t cwp_next);
        int base;
        case (sel[4:3])
            2'd0:    base = 0;
            2'd1:    base = 8 + 16 * int'(cwp);
            2'd2:    base = 16 + 16 * int'(cwp);
            default: base = 8 + 16 * int'(cwp_next);
        endcase
        return phys_t'(base + int'(sel[2:0]));
    endfunction

    assign cwp_inc = (cwp_q == cwp_t'(NWINDOWS - 1)) ? '0 : cwp_q + cwp_t'(1);
    assign cwp_dec = (cwp_q == '0) ? cwp_t'(NWINDOWS - 1) : cwp_q - cwp_t'(1);

    assign idx_a = map_reg(rf.Register_A_Select, cwp_q, cwp_inc);
    assign idx_b = map_reg(rf.Register_B_Select, cwp_q, cwp_inc);
    assign idx_w = map_reg(rf.Write_Select, cwp_q, cwp_inc);
    assign wr_en = rf.Write_Enable && (rf.Write_Select != 5'd0);

    // Bypass compares physical indices so aliased ins/outs of adjacent windows forward too.
    always_comb begin
        rd_a_d = regs[idx_a];
        rd_b_d = regs[idx_b];
        if (wr_en && (idx_a == idx_w)) rd_a_d = rf.Write_Data;
        if (wr_en && (idx_b == idx_w)) rd_b_d = rf.Write_Data;
        if (rf.Register_A_Select == 5'd0) rd_a_d = '0;
        if (rf.Register_B_Select == 5'd0) rd_b_d = '0;
    end

    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (rf.CWP_Op)
            2'b01: if (rf.WIM[cwp_dec]) ovf_d = 1'b1; else cwp_d = cwp_dec;
            2'b10: if (rf.WIM[cwp_inc]) unf_d = 1'b1; else cwp_d = cwp_inc;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
            cwp_q  <= cwp_t'(CWP_RESET);
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_en) regs[idx_w] <= rf.Write_Data;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            cwp_q  <= cwp_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign rf.Register_A       = rd_a_q;
    assign rf.Register_B       = rd_b_q;
    assign rf.CWP              = cwp_q;
    assign rf.Window_Overflow  = ovf_q;
    assign rf.Window_Underflow = unf_q;
endmodule
